// File: rtl/result_serializer_pkg.sv
// Shared types and helpers for the systolic-core result serializer.
package result_serializer_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_e;

    function automatic int frame_bits(input int n, input int d_w);
        return n * n * 2 * d_w;
    endfunction

    // Bit offset of flat element idx = i*N+j inside core_out_z.
    function automatic int elem_lsb(input int idx, input int d_w);
        return idx * 2 * d_w;
    endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Result bus between the systolic core/start logic and the serializer.
interface result_serializer_if
    import result_serializer_pkg::*;
#(
    parameter int D_W = 8,
    parameter int N   = 2
);
    logic [frame_bits(N, D_W)-1:0] core_out_z;
    logic                          init;
    logic                          data_out_z;
    logic                          tx_ready;
    logic                          frame_done;

    modport master (
        output core_out_z, init,
        input  data_out_z, tx_ready, frame_done
    );

    modport slave (
        input  core_out_z, init,
        output data_out_z, tx_ready, frame_done
    );
endinterface

// File: rtl/result_serializer_piso_shift.sv
// Parallel-load, serial-out register; shifts toward the MSB and fills with zeros.
module piso_shift #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);
    logic [W-1:0] r_sreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_clr) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            r_sreg <= {r_sreg[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_sreg[W-1];
endmodule

// File: rtl/result_serializer.sv
// Waits out the core drain latency after init, captures the N*N result and
// streams it MSB-first, element (0,0) first, on a single pin.
//
// state | meaning
// IDLE  | no frame pending, outputs low
// WAIT  | counting down the drain latency
// SHIFT | frame bits on data_out_z, tx_ready high
// DONE  | one-cycle frame_done pulse
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int D_W = 8,
    parameter int N   = 2,
    parameter int LAT = 3*N-2
) (
    input  logic              clk,
    input  logic              rst,
    result_serializer_if.slave s_bus
);
    localparam int FRAME = frame_bits(N, D_W);
    localparam int EW    = 2 * D_W;
    localparam int WCW   = $clog2(LAT + 1);
    localparam int BCW   = $clog2(FRAME);

    state_e           r_state;
    state_e           w_state_nx;
    logic [WCW-1:0]   r_wait_cnt;
    logic [BCW-1:0]   r_bit_cnt;
    logic             r_tx_ready;
    logic             r_frame_done;
    logic             w_restart;
    logic             w_wait_dec;
    logic             w_capture;
    logic             w_shift;
    logic             w_msb;
    logic [FRAME-1:0] w_frame;

    // Element 0 lands in the top slice so the MSB-first shift emits it first.
    for (genvar e = 0; e < N*N; e++) begin : g_order
        assign w_frame[FRAME-1-e*EW -: EW] = s_bus.core_out_z[elem_lsb(e, D_W) +: EW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_restart  = 1'b0;
        w_wait_dec = 1'b0;
        w_capture  = 1'b0;
        w_shift    = 1'b0;
        if (s_bus.init) begin
            w_restart  = 1'b1;
            w_state_nx = WAIT;
        end else begin
            case (r_state)
                IDLE: w_state_nx = IDLE;
                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        w_capture  = 1'b1;
                        w_state_nx = SHIFT;
                    end else begin
                        w_wait_dec = 1'b1;
                    end
                end
                SHIFT: begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == '0) begin
                        w_state_nx = DONE;
                    end
                end
                DONE:    w_state_nx = IDLE;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_tx_ready   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx_ready   <= (w_state_nx == SHIFT);
            r_frame_done <= (w_state_nx == DONE);
            if (w_restart) begin
                r_wait_cnt <= WCW'(LAT - 1);
            end else if (w_wait_dec) begin
                r_wait_cnt <= r_wait_cnt - WCW'(1);
            end
            if (w_capture) begin
                r_bit_cnt <= BCW'(FRAME - 1);
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt - BCW'(1);
            end
        end
    end

    // A restart clears the register so an aborted frame leaves the pin low.
    piso_shift #(.W(FRAME)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_restart),
        .i_load  (w_capture),
        .i_shift (w_shift),
        .i_data  (w_frame),
        .o_msb   (w_msb)
    );

    assign s_bus.data_out_z = w_msb;
    assign s_bus.tx_ready   = r_tx_ready;
    assign s_bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: frame-level reference model checked every cycle,
// fixed scenarios pinned with literal expectations, then randomized init traffic.
module tb_result_serializer;
    localparam int D_W   = 8;
    localparam int N     = 2;
    localparam int LAT   = 4;
    localparam int EW    = 2 * D_W;
    localparam int FRAME = N * N * EW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    result_serializer_if #(.D_W(D_W), .N(N)) bus();

    result_serializer #(.D_W(D_W), .N(N), .LAT(LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;
    bit   active = 1'b0;
    logic model_bits [FRAME];

    logic [15:0]      lit_a5  = 16'hA5C3;
    logic [15:0]      lit_02  = 16'h0002;
    logic [15:0]      lit_04  = 16'h0004;
    logic [FRAME-1:0] z_basic = {16'h0004, 16'h0003, 16'h0002, 16'hA5C3};

    // Reference: remember the last init edge and the frame captured LAT edges later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            active = 1'b0;
        end else if (bus.init) begin
            k      = cyc;
            active = 1'b1;
        end else if (active && cyc == k + LAT) begin
            for (int b = 0; b < FRAME; b++)
                model_bits[b] = bus.core_out_z[(b / EW) * EW + EW - 1 - (b % EW)];
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int   off;
        logic e_tx;
        logic e_d;
        logic e_fd;
        off  = cyc - k - LAT;
        e_tx = !rst && active && off >= 0 && off < FRAME;
        e_d  = e_tx ? model_bits[off] : 1'b0;
        e_fd = !rst && active && off == FRAME;
        check("tx_ready",   bus.tx_ready,   e_tx);
        check("data_out_z", bus.data_out_z, e_d);
        check("frame_done", bus.frame_done, e_fd);

        case (cyc)
            13, 78, 180, 270: check("pin_tx_low", bus.tx_ready, 1'b0);
            14, 77, 83, 164, 184, 284, 347, 364, 444: check("pin_tx_high", bus.tx_ready, 1'b1);
            default: ;
        endcase
        case (cyc)
            78, 147, 248, 348, 428, 508: check("pin_done_high", bus.frame_done, 1'b1);
            228, 270: check("pin_done_low", bus.frame_done, 1'b0);
            default: ;
        endcase
        if (cyc >= 14 && cyc <= 29)   check("pin_elem00", bus.data_out_z, lit_a5[29 - cyc]);
        if (cyc >= 30 && cyc <= 45)   check("pin_elem01", bus.data_out_z, lit_02[45 - cyc]);
        if (cyc >= 62 && cyc <= 77)   check("pin_elem11_isolated", bus.data_out_z, lit_04[77 - cyc]);
        if (cyc >= 284 && cyc <= 299) check("pin_elem00_after_rst", bus.data_out_z, lit_a5[299 - cyc]);
        if (cyc >= 364 && cyc <= 427) check("pin_zeros", bus.data_out_z, 1'b0);
        if (cyc >= 444 && cyc <= 507) check("pin_ones", bus.data_out_z, 1'b1);
        if (cyc == 270)               check("pin_rst_data", bus.data_out_z, 1'b0);
    end

    function automatic logic [FRAME-1:0] rnd();
        return {$urandom(), $urandom()};
    endfunction

    // Drive in the low phase of cycle c, so the values are sampled at edge c+1.
    task automatic drive(input int c, input logic ini, input logic [FRAME-1:0] z);
        do @(negedge clk); while (cyc < c);
        bus.init       = ini;
        bus.core_out_z = z;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        logic [FRAME-1:0] z;
        int c;
        bus.init       = 1'b0;
        bus.core_out_z = z_basic;
        drive(2, 1'b0, z_basic);
        rst = 1'b0;

        drive(9,  1'b1, z_basic);
        drive(10, 1'b0, z_basic);
        drive(14, 1'b0, '1);

        z = rnd();
        drive(78, 1'b1, z);
        drive(79, 1'b0, z);

        z = rnd();
        drive(159, 1'b1, z);
        drive(160, 1'b0, z);
        z = rnd();
        drive(179, 1'b1, z);
        drive(180, 1'b0, rnd());
        drive(184, 1'b0, rnd());

        drive(259, 1'b1, z_basic);
        drive(260, 1'b0, z_basic);
        drive(269, 1'b0, z_basic);
        @(posedge clk);
        #2 rst = 1'b1;
        drive(272, 1'b0, z_basic);
        rst = 1'b0;
        drive(279, 1'b1, z_basic);
        drive(280, 1'b0, z_basic);

        drive(359, 1'b1, '0);
        drive(360, 1'b0, '0);
        drive(439, 1'b1, '1);
        drive(440, 1'b0, '1);
        drive(520, 1'b0, '1);

        repeat (40) begin
            c = cyc + $urandom_range(1, 90);
            drive(c, 1'b1, rnd());
            drive(c + 1, ($urandom_range(0, 7) == 0), rnd());
            drive(c + 2, 1'b0, rnd());
        end

        drive(cyc + 100, 1'b0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
